image_sequencer: RTL

- Frame-synchronous controller for the screensaver image datapath.
- Decides which of the four stored images is displayed. Button selects take effect only at frame boundaries.
- After an idle period it enters an auto-cycle mode that steps through the images.
- Generates the registered ROM read address for the 4x-downscaled (160x120) image store from the VGA pixel coordinates.

---
 rtl/image_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/image_sequencer.sv
// image_sequencer: frame-synchronous image selection with idle auto-cycle,
// plus a one-cycle registered ROM address generator for the 4x-downscaled image store.
`default_nettype none

module image_sequencer #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int IDLE_FRAMES  = 600,
   parameter int DWELL_FRAMES = 180,
   parameter int ADDR_W       = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              frame_start_i,
   input  logic [3:0]        image_select_i,
   input  logic [9:0]        pixel_x_i,
   input  logic [9:0]        pixel_y_i,
   input  logic              pixel_valid_i,
   output logic [1:0]        current_image_o,
   output logic              auto_mode_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              rom_addr_valid_o
);

   localparam int IDLE_W  = $clog2(IDLE_FRAMES + 1);
   localparam int DWELL_W = $clog2(DWELL_FRAMES + 1);
   localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(IDLE_FRAMES);
   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_FRAMES);
   localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
   localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

   typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

   state_t              state;
   logic                pending_valid;
   logic [1:0]          pending_idx;
   logic [IDLE_W-1:0]   idle_cnt;
   logic [DWELL_W-1:0]  dwell_cnt;

   logic                sel_onehot;
   logic [1:0]          sel_idx;
   logic                req;
   logic [1:0]          req_idx;
   logic [IDLE_W-1:0]   idle_inc;
   logic [DWELL_W-1:0]  dwell_inc;

   always_comb begin
      sel_onehot = 1'b1;
      sel_idx    = 2'd0;
      case (image_select_i)
         4'b0001: sel_idx = 2'd0;
         4'b0010: sel_idx = 2'd1;
         4'b0100: sel_idx = 2'd2;
         4'b1000: sel_idx = 2'd3;
         default: sel_onehot = 1'b0;
      endcase
      // A select present on the boundary cycle itself beats any older pending one.
      req       = sel_onehot | pending_valid;
      req_idx   = sel_onehot ? sel_idx : pending_idx;
      idle_inc  = idle_cnt + 1'b1;
      dwell_inc = dwell_cnt + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= MANUAL;
         pending_valid   <= 1'b0;
         pending_idx     <= 2'd0;
         idle_cnt        <= '0;
         dwell_cnt       <= '0;
         current_image_o <= 2'd0;
         auto_mode_o     <= 1'b0;
      end else if (frame_start_i) begin
         pending_valid <= 1'b0;
         if (req) begin
            state           <= MANUAL;
            auto_mode_o     <= 1'b0;
            current_image_o <= req_idx;
            idle_cnt        <= '0;
            dwell_cnt       <= '0;
         end else if (state == MANUAL) begin
            idle_cnt <= idle_inc;
            if (idle_inc == IDLE_MAX) begin
               state       <= AUTO;
               auto_mode_o <= 1'b1;
               dwell_cnt   <= '0;
            end
         end else begin
            if (dwell_inc == DWELL_MAX) begin
               current_image_o <= current_image_o + 2'd1;
               dwell_cnt       <= '0;
            end else begin
               dwell_cnt <= dwell_inc;
            end
         end
      end else if (sel_onehot) begin
         pending_valid <= 1'b1;
         pending_idx   <= sel_idx;
      end
   end

   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] col_off;
   logic              addr_ok;

   assign col_off = ADDR_W'(pixel_x_i[9:2]);

   generate
      if (H_ACTIVE / 4 == 160) begin : g_mul160
         // 160*y = 128*y + 32*y keeps the multiply in plain adders.
         assign row_base = (ADDR_W'(pixel_y_i[9:2]) << 7) + (ADDR_W'(pixel_y_i[9:2]) << 5);
      end else begin : g_mul_generic
         assign row_base = ADDR_W'(pixel_y_i[9:2]) * ADDR_W'(H_ACTIVE / 4);
      end
   endgenerate

   assign addr_ok = pixel_valid_i && ({1'b0, pixel_x_i} < H_LIM) && ({1'b0, pixel_y_i} < V_LIM);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rom_addr_o       <= '0;
         rom_addr_valid_o <= 1'b0;
      end else begin
         rom_addr_valid_o <= addr_ok;
         rom_addr_o       <= addr_ok ? (row_base + col_off) : '0;
      end
   end

endmodule

`default_nettype wire
